// File: rtl/sign_truncate_sat.sv
// sign_truncate_sat
// Streaming signed narrowing stage. Packs a wide two's-complement sample
// back into a narrow bus word, either saturating or wrapping out-of-range
// values, and flags each such sample with ovf. Samples pass through a
// valid/ready stage made of an output register plus one skid entry, so the
// upstream in_ready can be registered without losing throughput.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input sample valid
//   in_ready   stage can accept (registered; low exactly when skid is full)
//   a          signed input sample, NUM_INPUTS bits
//   out_valid  output sample valid
//   out_ready  downstream accepts
//   z          narrowed signed sample, NUM_OUTPUTS bits
//   ovf        z came from an out-of-range input; travels with z
//   ovf_count  saturating count of delivered samples with ovf=1
//   clr_count  synchronous clear of ovf_count (wins over an increment)

module sign_truncate_sat #(
    parameter int NUM_INPUTS  = 32,
    parameter int NUM_OUTPUTS = 16,
    parameter int SAT_EN      = 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_INPUTS-1:0]  a,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_OUTPUTS-1:0] z,
    output logic                   ovf,
    output logic [CNT_WIDTH-1:0]   ovf_count,
    input  logic                   clr_count
);

    generate
        if (NUM_INPUTS <= NUM_OUTPUTS) begin : g_bad_width
            $error("sign_truncate_sat: NUM_INPUTS must be greater than NUM_OUTPUTS");
        end
        if (NUM_OUTPUTS < 2) begin : g_bad_out_width
            $error("sign_truncate_sat: NUM_OUTPUTS must be at least 2");
        end
    endgenerate

    // The bits that must all equal the result sign bit for the value to fit.
    localparam int TOP_W = NUM_INPUTS - NUM_OUTPUTS + 1;

    logic [TOP_W-1:0]       top_bits;
    logic                   ovf_in;
    logic [NUM_OUTPUTS-1:0] res;

    logic                   out_valid_q, out_valid_d;
    logic [NUM_OUTPUTS-1:0] z_q, z_d;
    logic                   ovf_q, ovf_d;
    logic                   skid_valid_q, skid_valid_d;
    logic [NUM_OUTPUTS-1:0] skid_z_q, skid_z_d;
    logic                   skid_ovf_q, skid_ovf_d;
    logic                   in_ready_q, in_ready_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic accept;
    logic consume;

    // Narrowing datapath
    always_comb begin
        top_bits = a[NUM_INPUTS-1:NUM_OUTPUTS-1];
        ovf_in   = !((&top_bits) || (~|top_bits));
        res      = a[NUM_OUTPUTS-1:0];
        if (ovf_in && (SAT_EN != 0)) begin
            // Negative overflow -> most negative code, positive -> most positive.
            res = {a[NUM_INPUTS-1], {(NUM_OUTPUTS-1){~a[NUM_INPUTS-1]}}};
        end
    end

    assign accept  = in_valid && in_ready_q;
    assign consume = out_valid_q && out_ready;

    // Output register + skid entry. The output slot frees when it is empty or
    // being consumed; it then takes the skid first (FIFO order), and the new
    // sample lands behind it in the skid.
    always_comb begin
        out_valid_d  = out_valid_q;
        z_d          = z_q;
        ovf_d        = ovf_q;
        skid_valid_d = skid_valid_q;
        skid_z_d     = skid_z_q;
        skid_ovf_d   = skid_ovf_q;

        if (!out_valid_q || consume) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                z_d          = skid_z_q;
                ovf_d        = skid_ovf_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_z_d   = res;
                    skid_ovf_d = ovf_in;
                end
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    z_d   = res;
                    ovf_d = ovf_in;
                end
            end
        end else if (accept) begin
            // Output stalled; skid is known empty because in_ready was high.
            skid_valid_d = 1'b1;
            skid_z_d     = res;
            skid_ovf_d   = ovf_in;
        end

        in_ready_d = !skid_valid_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (consume && ovf_q && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // in_ready resets low so it first rises on the edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            z_q          <= '0;
            ovf_q        <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_z_q     <= '0;
            skid_ovf_q   <= 1'b0;
            in_ready_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            z_q          <= z_d;
            ovf_q        <= ovf_d;
            skid_valid_q <= skid_valid_d;
            skid_z_q     <= skid_z_d;
            skid_ovf_q   <= skid_ovf_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign ovf       = ovf_q;
    assign in_ready  = in_ready_q;
    assign ovf_count = cnt_q;

endmodule
